// File: rtl/limn2600_cache_ctrl.sv
// limn2600_cache_ctrl: two-port direct-mapped word-line cache,
// write-through with write-allocate, plus whole-cache invalidate.
module limn2600_cache_ctrl #(
   parameter int NUM_ENTRIES = 1024,
   parameter int INDEX_BITS  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        a_req,
   input  logic [31:0] a_addr,
   output logic        a_ack,
   output logic [31:0] a_rdata,
   input  logic        b_req,
   input  logic        b_we,
   input  logic [31:0] b_addr,
   input  logic [31:0] b_wdata,
   output logic        b_ack,
   output logic [31:0] b_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   input  logic        inv,
   output logic        busy
);
   localparam int TAG_BITS = 32 - INDEX_BITS - 2;

   typedef enum logic [2:0] {
      FLUSH, IDLE, LOOKUP, FILL, WRITE
   } state_t;

   state_t                state_q, state_d;
   logic [INDEX_BITS-1:0] cnt_q, cnt_d;
   logic                  pend_q, pend_d;
   logic                  rr_b_q, rr_b_d;
   logic                  lat_b_q, lat_b_d;
   logic                  lat_we_q, lat_we_d;
   logic [31:0]           lat_addr_q, lat_addr_d;
   logic [31:0]           lat_wdata_q, lat_wdata_d;

   logic        a_ack_d, b_ack_d;
   logic        mem_req_d, mem_we_d, busy_d;
   logic [31:0] a_rdata_d, b_rdata_d;
   logic [31:0] mem_addr_d, mem_wdata_d;

   logic [NUM_ENTRIES-1:0] valid;
   logic [TAG_BITS-1:0]    tag_mem  [NUM_ENTRIES];
   logic [31:0]            data_mem [NUM_ENTRIES];

   logic [INDEX_BITS-1:0] lat_idx;
   logic [TAG_BITS-1:0]   lat_tag;
   logic                  hit, a_elig, b_elig, grant_b;
   logic                  line_we, flush_clr;
   logic [31:0]           line_data;

   assign lat_idx = lat_addr_q[INDEX_BITS+1:2];
   assign lat_tag = lat_addr_q[31:INDEX_BITS+2];
   assign hit     = valid[lat_idx] &&
                    (tag_mem[lat_idx] == lat_tag);

   // A port is not re-granted in the cycle its ack is visible.
   assign a_elig  = a_req && !a_ack;
   assign b_elig  = b_req && !b_ack;
   assign grant_b = b_elig && (!a_elig || rr_b_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q || inv;
      rr_b_d      = rr_b_q;
      lat_b_d     = lat_b_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata;
      b_rdata_d   = b_rdata;
      mem_req_d   = mem_req;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      line_we     = 1'b0;
      line_data   = mem_rdata;
      flush_clr   = 1'b0;
      unique case (state_q)
         FLUSH: begin
            flush_clr = 1'b1;
            pend_d    = 1'b0;
            cnt_d     = cnt_q + INDEX_BITS'(1);
            if (cnt_q == {INDEX_BITS{1'b1}})
               state_d = IDLE;
         end
         IDLE: begin
            if (pend_q) begin
               state_d = FLUSH;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else if (a_elig || b_elig) begin
               lat_b_d     = grant_b;
               lat_we_d    = grant_b && b_we;
               lat_addr_d  = grant_b ? b_addr : a_addr;
               lat_wdata_d = b_wdata;
               rr_b_d      = !grant_b;
               state_d     = LOOKUP;
            end
         end
         LOOKUP: begin
            if (lat_we_q) begin
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = lat_addr_q;
               mem_wdata_d = lat_wdata_q;
               state_d     = WRITE;
            end else if (hit) begin
               if (lat_b_q) begin
                  b_ack_d   = 1'b1;
                  b_rdata_d = data_mem[lat_idx];
               end else begin
                  a_ack_d   = 1'b1;
                  a_rdata_d = data_mem[lat_idx];
               end
               state_d = IDLE;
            end else begin
               mem_req_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = lat_addr_q;
               state_d    = FILL;
            end
         end
         FILL, WRITE: begin
            if (mem_ack) begin
               line_we   = 1'b1;
               line_data = lat_we_q ? lat_wdata_q
                                    : mem_rdata;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               if (lat_b_q) begin
                  b_ack_d = 1'b1;
                  if (!lat_we_q)
                     b_rdata_d = mem_rdata;
               end else begin
                  a_ack_d   = 1'b1;
                  a_rdata_d = mem_rdata;
               end
               state_d = IDLE;
            end
         end
         default: state_d = FLUSH;
      endcase
      busy_d = (state_d == FLUSH);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= FLUSH;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
         rr_b_q      <= 1'b0;
         lat_b_q     <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         a_ack       <= 1'b0;
         b_ack       <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         busy        <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         rr_b_q      <= rr_b_d;
         lat_b_q     <= lat_b_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         a_ack       <= a_ack_d;
         b_ack       <= b_ack_d;
         a_rdata     <= a_rdata_d;
         b_rdata     <= b_rdata_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         busy        <= busy_d;
      end
   end

   // Line storage needs no reset: FLUSH clears every valid bit.
   always_ff @(posedge clk) begin
      if (flush_clr)
         valid[cnt_q] <= 1'b0;
      else if (line_we)
         valid[lat_idx] <= 1'b1;
      if (line_we) begin
         tag_mem[lat_idx]  <= lat_tag;
         data_mem[lat_idx] <= line_data;
      end
   end
endmodule

// File: tb/tb_limn2600_cache_ctrl.sv
// tb_limn2600_cache_ctrl: directed vectors, corner sequences and
// randomized traffic against a map-based cache/memory model.
`timescale 1ns/1ps
module tb_limn2600_cache_ctrl;
   localparam int NE = 1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_req = 1'b0;
   logic [31:0] a_addr = '0;
   logic        a_ack;
   logic [31:0] a_rdata;
   logic        b_req = 1'b0;
   logic        b_we = 1'b0;
   logic [31:0] b_addr = '0;
   logic [31:0] b_wdata = '0;
   logic        b_ack;
   logic [31:0] b_rdata;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        inv = 1'b0;
   logic        busy;

   limn2600_cache_ctrl #(
      .NUM_ENTRIES(NE),
      .INDEX_BITS (10)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .a_req    (a_req),
      .a_addr   (a_addr),
      .a_ack    (a_ack),
      .a_rdata  (a_rdata),
      .b_req    (b_req),
      .b_we     (b_we),
      .b_addr   (b_addr),
      .b_wdata  (b_wdata),
      .b_ack    (b_ack),
      .b_rdata  (b_rdata),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_wdata(mem_wdata),
      .mem_ack  (mem_ack),
      .mem_rdata(mem_rdata),
      .inv      (inv),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          port;
      int          cycle;
      logic [31:0] rdata;
   } ack_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cycle;
   } memop_t;

   typedef struct {
      bit          pb;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wd;
      int          dly;
      bit          exp_mem;
      logic [31:0] exp_rd;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int viol    = 0;

   ack_t   acks[$];
   memop_t mops[$];

   logic [31:0] mem_model [int];
   int          cache_line [int];

   int mem_delay  = 0;
   int mem_wait   = 0;
   bit keep_req   = 1'b0;
   bit inv_on_mem = 1'b0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  nm, act, exp);
      end
   endtask

   function automatic logic [31:0] mem_rd(input logic [31:0] addr);
      int wa;
      wa = int'(addr >> 2);
      if (mem_model.exists(wa))
         return mem_model[wa];
      return (addr & ~32'h3) ^ 32'hA5C3_0F96;
   endfunction

   // One clock: sample just after the edge, act as the memory.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (a_ack && b_ack) viol++;
      if ((a_ack || b_ack) && busy) viol++;
      if ((a_ack || b_ack) && mem_req) viol++;
      if (a_ack) begin
         acks.push_back('{port: 0, cycle: cyc, rdata: a_rdata});
         if (!keep_req) a_req = 1'b0;
      end
      if (b_ack) begin
         acks.push_back('{port: 1, cycle: cyc, rdata: b_rdata});
         if (!keep_req) b_req = 1'b0;
      end
      if (inv) inv = 1'b0;
      if (mem_ack) begin
         mem_ack  = 1'b0;
         mem_wait = 0;
      end else if (mem_req) begin
         if (mem_wait == 0) begin
            mops.push_back('{we: mem_we, addr: mem_addr,
                             wdata: mem_wdata, cycle: cyc});
            if (inv_on_mem) begin
               inv        = 1'b1;
               inv_on_mem = 1'b0;
            end
         end
         if (mem_wait == mem_delay) begin
            if (mem_addr !== mops[$].addr) viol++;
            mem_ack = 1'b1;
            if (mem_we)
               mem_model[int'(mem_addr >> 2)] = mem_wdata;
            else
               mem_rdata = mem_rd(mem_addr);
         end else begin
            mem_wait++;
         end
      end
   endtask

   task automatic wait_acks(input int n, input int limit,
                            input string nm);
      int k;
      k = 0;
      while (acks.size() < n && k < limit) begin
         tick();
         k++;
      end
      if (acks.size() < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s timeout: got %0d acks, need %0d",
                  nm, acks.size(), n);
      end
   endtask

   task automatic wait_busy_low(input int limit, output int cnt);
      cnt = busy ? 1 : 0;
      while (busy && cnt < limit) begin
         tick();
         if (busy) cnt++;
      end
   endtask

   task automatic predict(input bit we, input logic [31:0] addr,
                          output bit em, output logic [31:0] er);
      int wa, idx;
      wa  = int'(addr >> 2);
      idx = wa % NE;
      em  = we || !(cache_line.exists(idx) &&
                    cache_line[idx] == wa);
      er  = mem_rd(addr);
   endtask

   task automatic txn(input bit pb, input bit we,
                      input logic [31:0] addr,
                      input logic [31:0] wd, input int dly,
                      input bit exp_mem,
                      input logic [31:0] exp_rd,
                      input string nm);
      int n0, exp_lat, wa;
      acks.delete();
      mops.delete();
      mem_delay = dly;
      exp_lat   = exp_mem ? dly + 3 : 2;
      tick();
      if (pb) begin
         b_req   = 1'b1;
         b_we    = we;
         b_addr  = addr;
         b_wdata = wd;
      end else begin
         a_req  = 1'b1;
         a_addr = addr;
      end
      n0 = cyc;
      wait_acks(1, 80, nm);
      if (acks.size() >= 1) begin
         chk({nm, " port"}, acks[0].port, pb);
         chk({nm, " latency"}, acks[0].cycle - n0, exp_lat);
         if (!we) chk({nm, " rdata"}, acks[0].rdata, exp_rd);
      end
      chk({nm, " mem ops"}, mops.size(), exp_mem);
      if (mops.size() >= 1) begin
         chk({nm, " mem_addr"}, mops[0].addr, addr);
         chk({nm, " mem_we"}, mops[0].we, we);
         chk({nm, " mem_req cycle"}, mops[0].cycle - n0, 2);
         if (we) chk({nm, " mem_wdata"}, mops[0].wdata, wd);
      end
      wa = int'(addr >> 2);
      cache_line[wa % NE] = wa;
   endtask

   task automatic mtxn(input bit pb, input bit we,
                       input logic [31:0] addr,
                       input logic [31:0] wd, input int dly,
                       input string nm);
      bit          em;
      logic [31:0] er;
      predict(we, addr, em, er);
      txn(pb, we, addr, wd, dly, em, er, nm);
   endtask

   vec_t vt[9];

   initial begin
      int bc, t0, n0;
      bit          rpb, rwe;
      logic [31:0] raddr;

      vt[0] = '{0, 0, 32'h1000, 0, 3, 1, 32'hDEADBEEF};
      vt[1] = '{0, 0, 32'h1000, 0, 0, 0, 32'hDEADBEEF};
      vt[2] = '{1, 1, 32'h2004, 32'h12345678, 2, 1, 0};
      vt[3] = '{0, 0, 32'h2004, 0, 0, 0, 32'h12345678};
      vt[4] = '{0, 0, 32'h2000, 0, 1, 1, 32'hCAFEF00D};
      vt[5] = '{0, 0, 32'h1000, 0, 0, 1, 32'hDEADBEEF};
      vt[6] = '{1, 0, 32'h1000, 0, 0, 0, 32'hDEADBEEF};
      vt[7] = '{1, 1, 32'h2000, 32'h0BADF00D, 4, 1, 0};
      vt[8] = '{0, 0, 32'h1000, 0, 2, 1, 32'hDEADBEEF};
      mem_model[int'(32'h1000 >> 2)] = 32'hDEADBEEF;
      mem_model[int'(32'h2000 >> 2)] = 32'hCAFEF00D;

      // Reset with both ports requesting: A must win first tie.
      a_req  = 1'b1;
      a_addr = 32'h3000;
      b_req  = 1'b1;
      b_we   = 1'b0;
      b_addr = 32'h4000;
      repeat (3) @(posedge clk);
      #1;
      chk("rst a_ack", a_ack, 0);
      chk("rst b_ack", b_ack, 0);
      chk("rst a_rdata", a_rdata, 0);
      chk("rst b_rdata", b_rdata, 0);
      chk("rst mem_req", mem_req, 0);
      chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", mem_addr, 0);
      chk("rst mem_wdata", mem_wdata, 0);
      chk("rst busy", busy, 1);
      rst = 1'b0;
      mem_delay = 1;
      wait_busy_low(1100, bc);
      chk("reset flush length", bc, NE);
      chk("acks during flush", acks.size(), 0);
      chk("mem ops during flush", mops.size(), 0);
      t0 = cyc;
      wait_acks(2, 100, "post-flush");
      if (acks.size() >= 2 && mops.size() >= 2) begin
         chk("tie first port", acks[0].port, 0);
         chk("tie first rdata", acks[0].rdata, mem_rd(32'h3000));
         chk("tie second port", acks[1].port, 1);
         chk("tie second rdata", acks[1].rdata, mem_rd(32'h4000));
         chk("tie first mem_addr", mops[0].addr, 32'h3000);
         chk("first mem_req cycle", mops[0].cycle - t0, 2);
         chk("tie second mem_addr", mops[1].addr, 32'h4000);
      end
      cache_line[0] = int'(32'h4000 >> 2);
      chk("protocol after reset", viol, 0);

      for (int i = 0; i < 9; i++)
         txn(vt[i].pb, vt[i].we, vt[i].addr, vt[i].wd,
             vt[i].dly, vt[i].exp_mem, vt[i].exp_rd,
             $sformatf("vec%0d", i));

      // Fairness: both ports hold hit requests continuously.
      mtxn(1, 1, 32'h0100, 32'h1111_2222, 1, "fair fill A");
      mtxn(1, 1, 32'h0200, 32'h3333_4444, 1, "fair fill B");
      acks.delete();
      mops.delete();
      tick();
      keep_req = 1'b1;
      a_req    = 1'b1;
      a_addr   = 32'h0100;
      b_req    = 1'b1;
      b_we     = 1'b0;
      b_addr   = 32'h0200;
      n0 = cyc;
      wait_acks(6, 60, "fairness");
      keep_req = 1'b0;
      a_req    = 1'b0;
      b_req    = 1'b0;
      if (acks.size() >= 6) begin
         chk("fair first ack cycle", acks[0].cycle - n0, 2);
         for (int i = 0; i < 6; i++) begin
            chk($sformatf("fair port %0d", i), acks[i].port, i % 2);
            chk($sformatf("fair rdata %0d", i), acks[i].rdata,
                (i % 2) ? 32'h3333_4444 : 32'h1111_2222);
            if (i > 0)
               chk($sformatf("fair spacing %0d", i),
                   acks[i].cycle - acks[i-1].cycle, 2);
         end
      end
      chk("fair mem ops", mops.size(), 0);

      // Invalidate raised in FILL; a second inv mid-flush is absorbed.
      acks.delete();
      mops.delete();
      mem_delay  = 3;
      inv_on_mem = 1'b1;
      tick();
      a_req  = 1'b1;
      a_addr = 32'h5008;
      wait_acks(1, 60, "inv fill");
      if (acks.size() >= 1)
         chk("inv fill rdata", acks[0].rdata, mem_rd(32'h5008));
      chk("inv was issued", inv_on_mem, 0);
      acks.delete();
      mops.delete();
      tick();
      chk("inv busy rise", busy, 1);
      bc = busy ? 1 : 0;
      while (busy && bc < 1100) begin
         if (bc == 500) inv = 1'b1;
         tick();
         if (busy) bc++;
      end
      chk("inv flush length", bc, NE);
      bc = 0;
      repeat (8) begin
         tick();
         if (busy) bc++;
      end
      chk("no second flush", bc, 0);
      chk("acks during inv flush", acks.size(), 0);
      chk("mem ops during inv flush", mops.size(), 0);
      cache_line.delete();
      txn(0, 0, 32'h1000, 0, 1, 1, 32'hDEADBEEF, "post-inv 0x1000");

      // Reset in the middle of a fill.
      acks.delete();
      mops.delete();
      mem_delay = 50;
      tick();
      a_req  = 1'b1;
      a_addr = 32'h6000;
      repeat (4) tick();
      chk("mid-fill mem_req", mem_req, 1);
      #2 rst = 1'b1;
      #1 chk("rst drops mem_req", mem_req, 0);
      a_req    = 1'b0;
      mem_ack  = 1'b0;
      repeat (3) tick();
      mem_wait = 0;
      chk("no ack after rst", acks.size(), 0);
      rst = 1'b0;
      cache_line.delete();
      wait_busy_low(1100, bc);
      chk("flush after rst", bc, NE);

      for (int i = 0; i < 150; i++) begin
         rpb   = 1'($urandom_range(0, 1));
         rwe   = rpb && ($urandom_range(0, 2) == 0);
         raddr = (32'($urandom_range(0, 3)) << 12) |
                 (32'($urandom_range(0, 1)) << 28) |
                 (32'($urandom_range(0, 7)) << 2);
         if (!rwe) raddr = raddr | 32'($urandom_range(0, 3));
         mtxn(rpb, rwe, raddr, $urandom, $urandom_range(0, 4),
              $sformatf("rnd%0d", i));
      end
      chk("protocol overall", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/limn2600_cache_ctrl.md
# limn2600_cache_ctrl

Two-port cache controller for the Limn2600 core. It arbitrates the instruction-fetch port (A) and the load/store port (B) onto one direct-mapped, word-line cache. Read misses are filled from the memory bus and writes go through to memory. It also owns the whole-cache invalidate sequence, run at reset and on request.

## Interface

- NUM_ENTRIES, 1024: cache lines, one 32-bit word each; power of two.
- INDEX_BITS, 10: log2(NUM_ENTRIES).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A read request; held stable until a_ack.
- a_addr  in  32  port A byte address (bits [1:0] ignored).
- a_ack  out  1  one-cycle completion pulse; a_rdata valid same cycle.
- a_rdata  out  32  port A read data.
- b_req, b_we  in  1 each  port B request; b_we=1 write, 0 read.
- b_addr, b_wdata  in  32 each  port B address / write data.
- b_ack  out  1  one-cycle completion pulse.
- b_rdata  out  32  port B read data (valid with b_ack on reads).
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr, mem_wdata  out  32 each  memory address / write data, stable while mem_req.
- mem_ack  in  1  memory completion; mem_rdata valid same cycle.
- mem_rdata  in  32  memory read data.
- inv  in  1  invalidate-all pulse.
- busy  out  1  high while invalidating.

## Operation

- **Address split:**
  - index = addr[INDEX_BITS+1:2].
  - tag = addr[31:INDEX_BITS+2].
  - Per-line storage: valid bit, tag, data.
- **States:** FLUSH, IDLE, LOOKUP, FILL, WRITE.
- **FLUSH:**
  - Clears valid[cnt] each cycle, with cnt running 0..NUM_ENTRIES-1.
  - At cnt=NUM_ENTRIES-1, goes to IDLE.
  - busy=1 throughout.
- **IDLE:**
  - A pending invalidate has priority: go to FLUSH with cnt=0.
  - Otherwise, grant an eligible requester. A port is ineligible in the cycle its ack is high.
  - Latch addr, we, wdata and the port id, then go to LOOKUP.
- **Arbitration:**
  - Round-robin. When both ports request, grant the port not granted last.
  - After reset, A wins the first tie.
- **LOOKUP:**
  - Read hit (valid and tag match): set that port's ack, load rdata from the line, go to IDLE.
  - Read miss: mem_req=1, mem_we=0, mem_addr=latched addr; go to FILL.
  - Write: mem_req=1, mem_we=1, mem_addr/mem_wdata=latched; go to WRITE.
- **FILL:**
  - On mem_ack: write line (data=mem_rdata, tag, valid=1), ack the port with rdata=mem_rdata, clear mem_req, go to IDLE.
- **WRITE:**
  - On mem_ack: write line (data=wdata, tag, valid=1; write-allocate), ack the port, clear mem_req, go to IDLE.
- **inv:**
  - Latched into a pending flag in any state.
  - An in-flight transaction completes and acks before FLUSH starts.
  - An inv arriving during FLUSH is absorbed, with no second pass.
- **Conflicts:** a different tag on the same index evicts the old line. A write followed by a read of the same address returns the written data from cache.

## Timing

- **Reset values:**
  - a_ack=b_ack=0, a_rdata=b_rdata=0.
  - mem_req=mem_we=0, mem_addr=mem_wdata=0.
  - state=FLUSH, cnt=0, busy=1, inv pending=0, round-robin favours A.
- **Reset mid-transaction:** mem_req drops immediately (asynchronously) and the transaction is abandoned, with no ack.
- **Outputs:** all registered, nothing combinational from inputs.
- **Hit latency:** req high in cycle N (IDLE) → LOOKUP in N+1 → ack in N+2. Back-to-back hits complete one per 3 cycles.
- **Miss/write latency:**
  - mem_req rises in N+2.
  - If mem_ack is sampled in cycle M, the port ack is in M+1 and mem_req is low in M+1.
- **Requester side:** may change req/addr at the edge ending the ack cycle. The new request is sampled in the following cycle.
- **Flush duration:** busy is high for NUM_ENTRIES cycles after reset release or after FLUSH entry. No ack is ever asserted while busy.
- **Ack exclusivity:** a_ack and b_ack are never high in the same cycle.

## Test plan

- **Reset flush:** release rst with a_req held → busy high exactly 1024 cycles; no mem_req and no a_ack until busy falls; then the request proceeds.
- **Read miss then hit:**
  - A reads 0x1000 → mem_req with mem_addr=0x1000, mem_we=0. Return mem_ack with 0xDEADBEEF after 3 cycles → a_ack with a_rdata=0xDEADBEEF the next cycle.
  - Re-read 0x1000 → a_ack 2 cycles after req, no mem_req.
- **Write-through and allocate:**
  - B writes 0x12345678 to 0x2004 → mem_we=1, mem_wdata=0x12345678; b_ack the cycle after mem_ack.
  - A then reads 0x2004 → hit, a_rdata=0x12345678, no memory traffic.
- **Eviction:** after filling 0x1000, read 0x2000 (same index 0, different tag) → miss and fill. A subsequent read of 0x1000 misses again.
- **Fairness:** A and B both request continuously with hits → grants alternate A,B,A,B; the first grant goes to A after reset.
- **Invalidate during fill:**
  - Pulse inv while in FILL → the fill completes and acks, then busy is high 1024 cycles, then a read of 0x1000 misses.
  - Separately, assert rst mid-FILL → mem_req low immediately and no ack.
